// File: rtl/step_clk_pkg.sv
// ---------------------------------------------------------------------------
// step_clk_pkg
// Shared definitions for the single-step manual clock generator:
//   - state_t    : FSM state encoding (IDLE / HIGH / LOW / DONE)
//   - DEF_*      : default pulse widths and burst-length field width
//   - max_int()  : constant helper used to size the phase timer
// ---------------------------------------------------------------------------
package step_clk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DEF_HIGH_CYC = 4;
    localparam int DEF_LOW_CYC  = 4;
    localparam int DEF_CNT_W    = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/step_clk_gen_phase_timer.sv
// ---------------------------------------------------------------------------
// phase_timer
// Loadable down-counter with a zero flag. Loading N makes zero assert on the
// N-th cycle after the load, so a load of WIDTH-1 yields a WIDTH-cycle phase.
// Ports:
//   rclk      : system clock (rising edge)
//   rst_n     : asynchronous active-low reset (count cleared)
//   load      : load load_val this cycle (takes priority over counting)
//   load_val  : value to load
//   zero      : count has reached zero (holds there until reloaded)
// ---------------------------------------------------------------------------
module phase_timer #(
    parameter int W = 3
) (
    input  logic         rclk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count_reg;

    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/step_clk_gen.sv
// ---------------------------------------------------------------------------
// step_clk_gen
// Turns an accepted burst request into exactly len glitch-free manual clock
// pulses (HIGH_CYC cycles high, LOW_CYC cycles low each), then pulses done.
// Optional free-running mode is compiled in with STEP_CLK_FREE_RUN_EN.
// Ports:
//   rclk      : system clock, all logic on its rising edge
//   rst_n     : asynchronous active-low reset (abandons any burst)
//   run       : (STEP_CLK_FREE_RUN_EN only) free-run while high
//   req_valid : burst request valid
//   req_len   : pulses requested, 0 treated as 1
//   req_ready : block can accept a request
//   clk_out   : generated manual clock, straight from a flop
//   busy      : burst in progress (HIGH, LOW or DONE)
//   done      : one-cycle pulse after the final low phase
//   pulse_cnt : pulses emitted in the current or last burst
// ---------------------------------------------------------------------------
module step_clk_gen
    import step_clk_pkg::*;
#(
    parameter int HIGH_CYC = DEF_HIGH_CYC,
    parameter int LOW_CYC  = DEF_LOW_CYC,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic             rclk,
    input  logic             rst_n,
`ifdef STEP_CLK_FREE_RUN_EN
    input  logic             run,
`endif
    input  logic             req_valid,
    input  logic [CNT_W-1:0] req_len,
    output logic             req_ready,
    output logic             clk_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pulse_cnt
);

    localparam int PH_W = $clog2(max_int(HIGH_CYC, LOW_CYC)) + 1;
    localparam logic [PH_W-1:0] HIGH_LOAD = PH_W'(HIGH_CYC - 1);
    localparam logic [PH_W-1:0] LOW_LOAD  = PH_W'(LOW_CYC - 1);

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  len_reg;
    logic [CNT_W-1:0]  pulse_cnt_reg;
    logic              clk_out_reg;
    logic              tmr_load;
    logic [PH_W-1:0]   tmr_val;
    logic              tmr_zero;
    logic              accept;
    logic              more_pulses;
`ifdef STEP_CLK_FREE_RUN_EN
    logic              free_reg;
    logic              start_free;
`endif

    phase_timer #(
        .W (PH_W)
    ) u_phase_timer (
        .rclk     (rclk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // Decide at the end of each LOW phase whether another pulse follows.
    // In free-run the level of run decides; otherwise the burst length.
`ifdef STEP_CLK_FREE_RUN_EN
    assign more_pulses = free_reg ? run : (pulse_cnt_reg != len_reg);
`else
    assign more_pulses = (pulse_cnt_reg != len_reg);
`endif

    // State register
    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic, including phase-timer reloads at every phase change
    always_comb begin
        state_next = state_reg;
        tmr_load   = 1'b0;
        tmr_val    = HIGH_LOAD;
        accept     = 1'b0;
`ifdef STEP_CLK_FREE_RUN_EN
        start_free = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
`ifdef STEP_CLK_FREE_RUN_EN
                if (run) begin
                    start_free = 1'b1;
                    state_next = HIGH;
                    tmr_load   = 1'b1;
                end else
`endif
                if (req_valid) begin
                    accept     = 1'b1;
                    state_next = HIGH;
                    tmr_load   = 1'b1;
                end
            end
            HIGH: begin
                if (tmr_zero) begin
                    state_next = LOW;
                    tmr_load   = 1'b1;
                    tmr_val    = LOW_LOAD;
                end
            end
            LOW: begin
                if (tmr_zero) begin
                    if (more_pulses) begin
                        state_next = HIGH;
                        tmr_load   = 1'b1;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output logic decoded from the current state
    always_comb begin
`ifdef STEP_CLK_FREE_RUN_EN
        req_ready = (state_reg == IDLE) && !run;
`else
        req_ready = (state_reg == IDLE);
`endif
        busy = (state_reg != IDLE);
        done = (state_reg == DONE);
    end

    // Datapath: clk_out is registered from the next state so that it rises
    // the cycle after acceptance and never carries decode glitches.
    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            clk_out_reg   <= 1'b0;
            len_reg       <= '0;
            pulse_cnt_reg <= '0;
`ifdef STEP_CLK_FREE_RUN_EN
            free_reg      <= 1'b0;
`endif
        end else begin
            clk_out_reg <= (state_next == HIGH);
            if (accept) begin
                len_reg       <= (req_len == '0) ? CNT_W'(1) : req_len;
                pulse_cnt_reg <= '0;
`ifdef STEP_CLK_FREE_RUN_EN
                free_reg      <= 1'b0;
`endif
            end
`ifdef STEP_CLK_FREE_RUN_EN
            if (start_free) begin
                pulse_cnt_reg <= '0;
                free_reg      <= 1'b1;
            end
`endif
            // A pulse is counted as its high phase ends; saturation only
            // matters in free-run, a burst never reaches all-ones + 1.
            if ((state_reg == HIGH) && tmr_zero && (pulse_cnt_reg != '1)) begin
                pulse_cnt_reg <= pulse_cnt_reg + 1'b1;
            end
        end
    end

    assign clk_out   = clk_out_reg;
    assign pulse_cnt = pulse_cnt_reg;

endmodule
